stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Time-base and counter chain feeding the FND display controller. It divides the system clock into 10 ms ticks and counts centiseconds, seconds, minutes and hours under a run/stop/clear state machine. Its four 7-bit binary outputs connect directly to the controller's `msec`, `sec`, `min` and `hour` inputs. Control pulses come from the debounced button front end.

## Interface
- `TICK_COUNT`, default 1_000_000: clk cycles per centisecond tick (100 MHz → 100 Hz).
- `MSEC_MOD`, default 100: centisecond modulus.
- `SEC_MOD`, default 60: seconds modulus.
- `MIN_MOD`, default 60: minutes modulus.
- `HOUR_MOD`, default 24: hours modulus.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `i_run_stop`  in  1  single-cycle pulse; toggles between RUN and STOP.
- `i_clear`  in  1  single-cycle pulse; zeroes all counters when stopped.
- `i_lap`  in  1  single-cycle pulse; toggles lap freeze. Present only with `STOPWATCH_LAP_EN`.
- `o_msec`  out  7  centiseconds, 0..MSEC_MOD-1.
- `o_sec`  out  7  seconds, 0..SEC_MOD-1.
- `o_min`  out  7  minutes, 0..MIN_MOD-1.
- `o_hour`  out  7  hours, 0..HOUR_MOD-1.
- `o_running`  out  1  high while in RUN.
- `o_lap_active`  out  1  high while outputs are frozen. Present only with `STOPWATCH_LAP_EN`.

## Operation
- FSM states: STOP (reset state), RUN, CLEAR.
- STOP: `i_clear` → CLEAR. Otherwise `i_run_stop` → RUN. When both are asserted in the same cycle, clear wins.
- RUN: `i_run_stop` → STOP. `i_clear` is ignored.
- CLEAR: lasts one cycle. Zeroes the prescaler and all counters, then goes to STOP unconditionally. Inputs asserted during CLEAR are ignored.
- Prescaler, width `$clog2(TICK_COUNT)`:
  - Increments only in RUN and holds its value in STOP, so a resumed run completes the partial period.
  - At `TICK_COUNT-1` it wraps to 0 and asserts the internal `tick` for one cycle.
- Counter chain:
  - `tick` increments msec.
  - msec at `MSEC_MOD-1` wraps to 0 and carries to sec in the same edge. sec carries to min and min carries to hour the same way.
  - hour wraps from `HOUR_MOD-1` to 0 with no overflow flag. 23:59:59.99 + tick → 00:00:00.00, with all four counters changing on one edge.
- Every counter is a registered binary count, never BCD; digit splitting happens downstream. Values never leave 0..MOD-1.
- `o_running` is a registered decode of state == RUN.
- Reset sets state STOP, prescaler 0, all counters 0, every output 0 and lap state 0. Reset asserted mid-run takes effect immediately (asynchronous).

## Timing
- A `i_run_stop` pulse sampled at edge k puts the FSM in RUN from cycle k+1, and `o_running` is high from k+1.
- First msec increment: `TICK_COUNT` cycles after the first RUN cycle when starting from prescaler 0.
- Carries are combinational within the chain. All counters update on the same edge as `tick`, so there is no ripple latency.
- A stop pulse at edge k freezes counts from k+1. A `tick` coinciding with edge k still applies.
- `i_clear` at edge k (in STOP): state CLEAR at k+1, outputs 0 after edge k+1, state STOP at k+2.
- All outputs are registered with no combinational path from inputs.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - `i_lap` toggles `o_lap_active` in RUN or STOP.
  - On the edge where lap is set, the current count is captured into shadow registers. While set, the outputs drive the shadow and internal counting continues.
  - Clearing the lap switches the outputs back to live counts on the next cycle.
  - CLEAR and reset force lap inactive.
- Undefined: no `i_lap`/`o_lap_active` ports and no shadow registers; outputs are always live counts.

## Structure
- Shared package `stopwatch_pkg` holds:
  - FSM state typedef (STOP, RUN, CLEAR).
  - Default modulus and `TICK_COUNT` constants.
  - Output width constant `TIME_W = 7`.
- Sub-module `time_counter`:
  - Parameters: `MOD`, `WIDTH`.
  - Inputs: `clk`, `reset`, `i_tick`, `i_clear`.
  - Outputs: `o_count`, combinational `o_carry = i_tick && count == MOD-1`.
  - Instantiated four times and chained carry → tick.
- Prescaler, FSM and lap logic live in `stopwatch_core`.

## Test plan
- Reset with `TICK_COUNT=4`: all outputs 0, `o_running=0`. Without a run pulse, 100 cycles → outputs remain 0.
- Run pulse, then 40 cycles → `o_msec=10`, `o_running=1`. Stop pulse → value holds for 50 cycles. Run again → resumes without a lost partial tick.
- Preload via 99 ticks then one more → `o_msec` 99→0 and `o_sec` 0→1 on the same edge.
- Run to 23:59:59.99, one tick → all outputs 0 on a single edge.
- In STOP, `i_run_stop` and `i_clear` in the same cycle → CLEAR then STOP, outputs 0, `o_running=0`. `i_clear` during RUN → ignored, counting continues.
- With `STOPWATCH_LAP_EN`: lap at msec=5 → outputs hold 5 while internal count reaches 20. Lap again → `o_msec=20` next cycle. Reset mid-lap → `o_lap_active=0`.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
//   - sw_state_e   : run/stop/clear FSM state
//   - DEF_*        : default moduli and prescaler period (100 MHz -> 100 Hz)
//   - TIME_W       : width of every time output
package stopwatch_pkg;

    localparam int unsigned TIME_W         = 7;

    localparam int unsigned DEF_TICK_COUNT = 1_000_000;
    localparam int unsigned DEF_MSEC_MOD   = 100;
    localparam int unsigned DEF_SEC_MOD    = 60;
    localparam int unsigned DEF_MIN_MOD    = 60;
    localparam int unsigned DEF_HOUR_MOD   = 24;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_e;

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/time bus between the button front end, the stopwatch core and the
// FND display controller.
//   i_run_stop, i_clear : single-cycle control pulses (into the core)
//   o_msec..o_hour      : binary time counts (out of the core)
//   o_running           : high while running
//   i_lap, o_lap_active : lap freeze, only when STOPWATCH_LAP_EN is defined
// Modports: master = stimulus/consumer side, slave = stopwatch_core.
interface stopwatch_core_if;
    import stopwatch_pkg::*;

    logic              i_run_stop;
    logic              i_clear;
    logic [TIME_W-1:0] o_msec;
    logic [TIME_W-1:0] o_sec;
    logic [TIME_W-1:0] o_min;
    logic [TIME_W-1:0] o_hour;
    logic              o_running;
`ifdef STOPWATCH_LAP_EN
    logic              i_lap;
    logic              o_lap_active;

    modport master (
        output i_run_stop, i_clear, i_lap,
        input  o_msec, o_sec, o_min, o_hour, o_running, o_lap_active
    );
    modport slave (
        input  i_run_stop, i_clear, i_lap,
        output o_msec, o_sec, o_min, o_hour, o_running, o_lap_active
    );
`else
    modport master (
        output i_run_stop, i_clear,
        input  o_msec, o_sec, o_min, o_hour, o_running
    );
    modport slave (
        input  i_run_stop, i_clear,
        output o_msec, o_sec, o_min, o_hour, o_running
    );
`endif

endinterface

// File: rtl/time_counter.sv
// One stage of the time chain: modulo-MOD binary counter.
//   clk, reset : clock, asynchronous active-high reset
//   i_tick     : advance by one
//   i_clear    : synchronous zero (takes priority)
//   o_count    : registered count, 0..MOD-1
//   o_carry    : combinational, i_tick while at MOD-1 (ticks the next stage)
module time_counter #(
    parameter int unsigned MOD   = 60,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max;

    assign at_max = (count_q == MAX);

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_tick) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_carry = i_tick && at_max;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time base: prescaler producing a centisecond tick, run/stop/clear
// FSM and a four-stage msec/sec/min/hour counter chain.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : stopwatch_core_if.slave (control pulses in, time counts out)
// Optional lap freeze is built when STOPWATCH_LAP_EN is defined: a lap pulse
// captures the live count into shadow registers which then drive the outputs
// while counting continues underneath.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_COUNT = DEF_TICK_COUNT,
    parameter int unsigned MSEC_MOD   = DEF_MSEC_MOD,
    parameter int unsigned SEC_MOD    = DEF_SEC_MOD,
    parameter int unsigned MIN_MOD    = DEF_MIN_MOD,
    parameter int unsigned HOUR_MOD   = DEF_HOUR_MOD
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_core_if.slave  bus
);

    localparam int unsigned PRE_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_COUNT - 1);

    sw_state_e         state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              running_q, running_d;
    logic              tick;
    logic              clr;

    logic [TIME_W-1:0] msec_cnt, sec_cnt, min_cnt, hour_cnt;
    logic              msec_carry, sec_carry, min_carry;
    logic              hour_carry_unused;

    // Prescaler only advances in RUN, so a stop/resume keeps the partial period.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (bus.i_clear) begin
                    state_d = ST_CLEAR;
                end else if (bus.i_run_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    tick  = 1'b1;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
                if (bus.i_run_stop) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: begin
                pre_d   = '0;
                clr     = 1'b1;
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
        // Decoded from the next state so o_running rises with the RUN state.
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STOP;
            pre_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            running_q <= running_d;
        end
    end

    time_counter #(.MOD(MSEC_MOD), .WIDTH(TIME_W)) u_msec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (tick),
        .i_clear (clr),
        .o_count (msec_cnt),
        .o_carry (msec_carry)
    );

    time_counter #(.MOD(SEC_MOD), .WIDTH(TIME_W)) u_sec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (msec_carry),
        .i_clear (clr),
        .o_count (sec_cnt),
        .o_carry (sec_carry)
    );

    time_counter #(.MOD(MIN_MOD), .WIDTH(TIME_W)) u_min (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (sec_carry),
        .i_clear (clr),
        .o_count (min_cnt),
        .o_carry (min_carry)
    );

    // Hours wrap silently; there is no overflow indication.
    time_counter #(.MOD(HOUR_MOD), .WIDTH(TIME_W)) u_hour (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (min_carry),
        .i_clear (clr),
        .o_count (hour_cnt),
        .o_carry (hour_carry_unused)
    );

    assign bus.o_running = running_q;

`ifdef STOPWATCH_LAP_EN
    logic                   lap_q, lap_d;
    logic [3:0][TIME_W-1:0] shadow_q, shadow_d;

    // Capture uses the count before the lap edge; CLEAR overrides any lap pulse.
    always_comb begin
        lap_d    = lap_q;
        shadow_d = shadow_q;
        if (state_q == ST_CLEAR) begin
            lap_d = 1'b0;
        end else if (bus.i_lap) begin
            lap_d = ~lap_q;
            if (!lap_q) begin
                shadow_d = {hour_cnt, min_cnt, sec_cnt, msec_cnt};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            lap_q    <= lap_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.o_msec       = lap_q ? shadow_q[0] : msec_cnt;
    assign bus.o_sec        = lap_q ? shadow_q[1] : sec_cnt;
    assign bus.o_min        = lap_q ? shadow_q[2] : min_cnt;
    assign bus.o_hour       = lap_q ? shadow_q[3] : hour_cnt;
    assign bus.o_lap_active = lap_q;
`else
    assign bus.o_msec = msec_cnt;
    assign bus.o_sec  = sec_cnt;
    assign bus.o_min  = min_cnt;
    assign bus.o_hour = hour_cnt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with small moduli so the full
// hour wrap is reachable. The reference model tracks the number of RUN
// cycles since the last clear and derives every time field from it by
// division and modulo; lap state is a captured copy of those fields.
// Exercise the lap feature by compiling with STOPWATCH_LAP_EN defined.
module tb_stopwatch_core;

    localparam int unsigned T_TICK = 4;
    localparam int unsigned T_MS   = 100;
    localparam int unsigned T_S    = 4;
    localparam int unsigned T_M    = 3;
    localparam int unsigned T_H    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stopwatch_core_if bus ();

    stopwatch_core #(
        .TICK_COUNT (T_TICK),
        .MSEC_MOD   (T_MS),
        .SEC_MOD    (T_S),
        .MIN_MOD    (T_M),
        .HOUR_MOD   (T_H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned       m_state = 0;   // 0 stopped, 1 running, 2 clearing
    longint unsigned   m_cyc   = 0;   // RUN cycles since last clear/reset
    bit                m_lap   = 1'b0;
    longint unsigned   m_sh [4] = '{0, 0, 0, 0};

    function automatic longint unsigned live(input int idx, input longint unsigned cyc);
        longint unsigned t;
        t = cyc / T_TICK;
        case (idx)
            0:       return t % T_MS;
            1:       return (t / T_MS) % T_S;
            2:       return (t / (T_MS * T_S)) % T_M;
            default: return (t / (T_MS * T_S * T_M)) % T_H;
        endcase
    endfunction

    function automatic longint unsigned expect_out(input int idx);
        return m_lap ? m_sh[idx] : live(idx, m_cyc);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_cyc   = 0;
            m_lap   = 1'b0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (m_state == 2) begin
                m_lap = 1'b0;
            end else if (bus.i_lap) begin
                if (!m_lap) begin
                    for (int i = 0; i < 4; i++) m_sh[i] = live(i, m_cyc);
                end
                m_lap = !m_lap;
            end
`endif
            case (m_state)
                0: begin
                    if (bus.i_clear)         m_state = 2;
                    else if (bus.i_run_stop) m_state = 1;
                end
                1: begin
                    m_cyc++;
                    if (bus.i_run_stop) m_state = 0;
                end
                default: begin
                    m_cyc   = 0;
                    m_state = 0;
                end
            endcase
        end
    end

    // Every cycle out of reset, outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("msec",    bus.o_msec,    expect_out(0));
            check("sec",     bus.o_sec,     expect_out(1));
            check("min",     bus.o_min,     expect_out(2));
            check("hour",    bus.o_hour,    expect_out(3));
            check("running", bus.o_running, (m_state == 1) ? 1 : 0);
`ifdef STOPWATCH_LAP_EN
            check("lap_active", bus.o_lap_active, m_lap ? 1 : 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input bit rs, input bit cl, input bit lp);
        bus.i_run_stop = rs;
        bus.i_clear    = cl;
`ifdef STOPWATCH_LAP_EN
        bus.i_lap      = lp;
`endif
        @(negedge clk);
        bus.i_run_stop = 1'b0;
        bus.i_clear    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.i_lap      = 1'b0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_msec"},    bus.o_msec,    0);
        check({tag, "_sec"},     bus.o_sec,     0);
        check({tag, "_min"},     bus.o_min,     0);
        check({tag, "_hour"},    bus.o_hour,    0);
        check({tag, "_running"}, bus.o_running, 0);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
`ifdef STOPWATCH_LAP_EN
        check({tag, "_lap"}, bus.o_lap_active, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    int unsigned n;
    logic [6:0]  p_ms, p_s, p_m, p_h;

    initial begin
        bus.i_run_stop = 1'b0;
        bus.i_clear    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.i_lap      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // Idle: nothing moves without a run pulse.
        repeat (100) @(negedge clk);
        check("idle_msec", bus.o_msec, 0);

        // Run 40 cycles at 4 cycles/tick -> 10.
        pulse(1, 0, 0);
        repeat (40) @(negedge clk);
        check("run40_msec", bus.o_msec, 10);
        check("run40_running", bus.o_running, 1);

        // Stop edge still counts (41 cycles -> 10), then hold.
        pulse(1, 0, 0);
        repeat (50) @(negedge clk);
        check("hold_msec", bus.o_msec, 10);
        check("hold_running", bus.o_running, 0);

        // Resume completes the partial period: 43 cycles -> 10, 44 -> 11.
        pulse(1, 0, 0);
        repeat (2) @(negedge clk);
        check("resume43_msec", bus.o_msec, 10);
        @(negedge clk);
        check("resume44_msec", bus.o_msec, 11);

        // msec 99 -> 0 and sec 0 -> 1 on the same edge.
        n = 0;
        while (!(bus.o_msec == 99 && bus.o_sec == 0) && n < 2000) begin
            @(negedge clk); n++;
        end
        check("wait99_timeout", (n < 2000) ? 1 : 0, 1);
        n = 0;
        while (bus.o_msec == 99 && n < 20) begin
            @(negedge clk); n++;
        end
        check("carry_msec", bus.o_msec, 0);
        check("carry_sec",  bus.o_sec,  1);

        // Full wrap: max value -> all zero on one edge.
        n = 0;
        while (!(bus.o_msec == T_MS-1 && bus.o_sec == T_S-1 &&
                 bus.o_min == T_M-1 && bus.o_hour == T_H-1) && n < 20000) begin
            @(negedge clk); n++;
        end
        check("waitmax_timeout", (n < 20000) ? 1 : 0, 1);
        n = 0;
        while (bus.o_msec == T_MS-1 && n < 20) begin
            @(negedge clk); n++;
        end
        check("wrap_msec", bus.o_msec, 0);
        check("wrap_sec",  bus.o_sec,  0);
        check("wrap_min",  bus.o_min,  0);
        check("wrap_hour", bus.o_hour, 0);

        // Stop, then run+clear together: clear wins.
        repeat (20) @(negedge clk);
        pulse(1, 0, 0);
        check("prestop_nonzero", (bus.o_msec != 0) ? 1 : 0, 1);
        pulse(1, 1, 0);
        check("clear_state_running", bus.o_running, 0);
        @(negedge clk);
        check_all_zero("cleared");
        @(negedge clk);
        check("after_clear_running", bus.o_running, 0);

        // Clear in RUN is ignored: 41 run cycles -> 10.
        pulse(1, 0, 0);
        repeat (30) @(negedge clk);
        pulse(0, 1, 0);
        repeat (10) @(negedge clk);
        check("clear_in_run_msec", bus.o_msec, 10);
        check("clear_in_run_running", bus.o_running, 1);

        // Asynchronous reset mid-run.
        async_reset("async");

`ifdef STOPWATCH_LAP_EN
        pulse(1, 0, 0);
        n = 0;
        while (bus.o_msec != 5 && n < 200) begin
            @(negedge clk); n++;
        end
        check("lap_wait5_timeout", (n < 200) ? 1 : 0, 1);
        pulse(0, 0, 1);
        check("lap_set_active", bus.o_lap_active, 1);
        check("lap_set_msec", bus.o_msec, 5);
        n = 0;
        while (!(live(0, m_cyc) == 20 && (m_cyc % T_TICK) == 0) && n < 200) begin
            @(negedge clk); n++;
        end
        check("lap_wait20_timeout", (n < 200) ? 1 : 0, 1);
        check("lap_frozen_msec", bus.o_msec, 5);
        pulse(0, 0, 1);
        check("lap_release_msec", bus.o_msec, 20);
        check("lap_release_active", bus.o_lap_active, 0);
        pulse(0, 0, 1);
        repeat (7) @(negedge clk);
        check("lap_again_active", bus.o_lap_active, 1);
        async_reset("lap_reset");
`endif

        // Random control pulses, model-checked every cycle.
        for (int c = 0; c < 4000; c++) begin
            bus.i_run_stop = ($urandom_range(0, 29) == 0);
            bus.i_clear    = ($urandom_range(0, 59) == 0);
`ifdef STOPWATCH_LAP_EN
            bus.i_lap      = ($urandom_range(0, 24) == 0);
`endif
            @(negedge clk);
        end
        bus.i_run_stop = 1'b0;
        bus.i_clear    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.i_lap      = 1'b0;
`endif
        repeat (5) @(negedge clk);

        // Keep the variables referenced for readability of captured state.
        p_ms = bus.o_msec; p_s = bus.o_sec; p_m = bus.o_min; p_h = bus.o_hour;
        check("final_msec_range", (p_ms < T_MS) ? 1 : 0, 1);
        check("final_sec_range",  (p_s  < T_S)  ? 1 : 0, 1);
        check("final_min_range",  (p_m  < T_M)  ? 1 : 0, 1);
        check("final_hour_range", (p_h  < T_H)  ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
